// File: rtl/terminal_pkg.sv
// Shared constants and state encoding for the terminal character writer.
package terminal_pkg;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_TAB   = 8'h09;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        PUT,
        CLEAR_ROW
    } terminal_writer_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N register: wraps explicitly at N-1, so N need not be a power of two.
module wrap_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] r_value;

    assign value = r_value;
    assign last  = (r_value == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset)
            r_value <= '0;
        else if (load)
            r_value <= load_val;
        else if (inc)
            r_value <= last ? '0 : r_value + W'(1);
    end

endmodule

// File: rtl/terminal_writer.sv
// Character stream to VRAM writer: printable output, BS/TAB/LF/CR/FF handling,
// and scrolling through a moving top_row rather than copying VRAM.
module terminal_writer
    import terminal_pkg::*;
#(
    parameter int ROWS      = 32,
    parameter int COLS      = 128,
    parameter int ROW_BITS  = $clog2(ROWS),
    parameter int COL_BITS  = $clog2(COLS),
    parameter int TAB_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                character_ready,
    input  logic                character_valid,
    input  logic [7:0]          character_byte,
    input  logic                write_ready,
    output logic                write_valid,
    output logic [ROW_BITS-1:0] write_row,
    output logic [COL_BITS-1:0] write_col,
    output logic [7:0]          write_byte,
    output logic [ROW_BITS-1:0] top_row,
    output logic [ROW_BITS-1:0] cursor_row,
    output logic [COL_BITS-1:0] cursor_col
);

    terminal_writer_state_t r_state, w_state_nxt;
    logic                   r_write_valid;
    logic [7:0]             r_char;

    logic [ROW_BITS-1:0] w_top, w_crow, w_srow, w_crow_next;
    logic [COL_BITS-1:0] w_ccol, w_scol, w_ccol_ld_val, w_tab_col;
    logic w_top_last_unused, w_crow_last, w_ccol_last, w_scol_last, w_srow_last;
    logic w_top_inc, w_crow_inc, w_crow_load, w_ccol_inc, w_ccol_load;
    logic w_scol_inc, w_srow_inc, w_hs, w_newline, w_at_bottom;
    int   w_tab;

    wrap_counter #(.N(ROWS), .W(ROW_BITS)) u_top (
        .clk(clk), .reset(reset), .inc(w_top_inc), .load(1'b0), .load_val('0),
        .value(w_top), .last(w_top_last_unused));
    wrap_counter #(.N(ROWS), .W(ROW_BITS)) u_crow (
        .clk(clk), .reset(reset), .inc(w_crow_inc), .load(w_crow_load), .load_val(w_top),
        .value(w_crow), .last(w_crow_last));
    wrap_counter #(.N(COLS), .W(COL_BITS)) u_ccol (
        .clk(clk), .reset(reset), .inc(w_ccol_inc), .load(w_ccol_load), .load_val(w_ccol_ld_val),
        .value(w_ccol), .last(w_ccol_last));
    wrap_counter #(.N(COLS), .W(COL_BITS)) u_scol (
        .clk(clk), .reset(reset), .inc(w_scol_inc), .load(1'b0), .load_val('0),
        .value(w_scol), .last(w_scol_last));
    wrap_counter #(.N(ROWS), .W(ROW_BITS)) u_srow (
        .clk(clk), .reset(reset), .inc(w_srow_inc), .load(1'b0), .load_val('0),
        .value(w_srow), .last(w_srow_last));

    // Cursor sits on the bottom screen line when one more row would land on top_row.
    assign w_crow_next = w_crow_last ? '0 : w_crow + ROW_BITS'(1);
    assign w_at_bottom = (w_crow_next == w_top);
    assign w_hs        = r_write_valid & write_ready;
    assign w_tab       = (int'(w_ccol) / TAB_WIDTH + 1) * TAB_WIDTH;
    assign w_tab_col   = (w_tab > COLS - 1) ? COL_BITS'(COLS - 1) : COL_BITS'(w_tab);

    always_comb begin
        w_state_nxt   = r_state;
        w_top_inc     = 1'b0;
        w_crow_inc    = 1'b0;
        w_crow_load   = 1'b0;
        w_ccol_inc    = 1'b0;
        w_ccol_load   = 1'b0;
        w_ccol_ld_val = '0;
        w_scol_inc    = 1'b0;
        w_srow_inc    = 1'b0;
        w_newline     = 1'b0;
        case (r_state)
            CLEAR_ALL: if (w_hs) begin
                w_scol_inc = 1'b1;
                if (w_scol_last) begin
                    w_srow_inc = 1'b1;
                    if (w_srow_last) begin
                        w_state_nxt = IDLE;
                        w_crow_load = 1'b1;
                        w_ccol_load = 1'b1;
                    end
                end
            end
            IDLE: if (character_valid) begin
                if (character_byte >= 8'h20 && character_byte <= 8'h7E)
                    w_state_nxt = PUT;
                else begin
                    case (character_byte)
                        CHAR_LF:  w_newline = 1'b1;
                        CHAR_CR:  w_ccol_load = 1'b1;
                        CHAR_BS:  begin
                            w_ccol_load   = (w_ccol != '0);
                            w_ccol_ld_val = w_ccol - COL_BITS'(1);
                        end
                        CHAR_TAB: begin
                            w_ccol_load   = 1'b1;
                            w_ccol_ld_val = w_tab_col;
                        end
                        CHAR_FF:  w_state_nxt = CLEAR_ALL;
                        default:  ;
                    endcase
                end
            end
            PUT: if (w_hs) begin
                w_ccol_inc  = 1'b1;
                w_newline   = w_ccol_last;
                w_state_nxt = IDLE;
            end
            CLEAR_ROW: if (w_hs) begin
                w_scol_inc = 1'b1;
                if (w_scol_last)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = CLEAR_ALL;
        endcase
        if (w_newline) begin
            w_crow_inc = 1'b1;
            if (w_at_bottom) begin
                w_top_inc   = 1'b1;
                w_state_nxt = CLEAR_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= CLEAR_ALL;
            r_write_valid <= 1'b0;
            r_char        <= CHAR_SPACE;
        end else begin
            r_state       <= w_state_nxt;
            r_write_valid <= (w_state_nxt != IDLE);
            if (r_state == IDLE && character_valid)
                r_char <= character_byte;
        end
    end

    assign character_ready = (r_state == IDLE);
    assign write_valid     = r_write_valid;
    assign write_byte      = (r_state == PUT) ? r_char : CHAR_SPACE;
    assign write_row       = (r_state == CLEAR_ALL) ? w_srow : w_crow;
    assign write_col       = (r_state == PUT) ? w_ccol : w_scol;
    assign top_row         = w_top;
    assign cursor_row      = w_crow;
    assign cursor_col      = w_ccol;

endmodule

// File: tb/tb_terminal_writer.sv
// Bench for terminal_writer (4x8, tab 4): directed scenarios plus random
// character/backpressure traffic against a screen-level reference model.
module tb_terminal_writer;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int TABW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       character_ready, character_valid = 1'b0;
    logic [7:0] character_byte = 8'h00;
    logic       write_ready = 1'b1, write_valid;
    logic [1:0] write_row, top_row, cursor_row;
    logic [2:0] write_col, cursor_col;
    logic [7:0] write_byte;

    terminal_writer #(.ROWS(ROWS), .COLS(COLS), .TAB_WIDTH(TABW)) dut (
        .clk(clk), .reset(reset),
        .character_ready(character_ready), .character_valid(character_valid),
        .character_byte(character_byte), .write_ready(write_ready),
        .write_valid(write_valid), .write_row(write_row), .write_col(write_col),
        .write_byte(write_byte), .top_row(top_row), .cursor_row(cursor_row),
        .cursor_col(cursor_col));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0, wcnt = 0, wr_mode = 0;
    int m_row = 0, m_col = 0, m_top = 0;
    int qr[$], qc[$], qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: screen-level rules, writes queued in issue order.
    function automatic void push_blank_row(input int r);
        for (int c = 0; c < COLS; c++) begin qr.push_back(r); qc.push_back(c); qb.push_back(32); end
    endfunction

    function automatic void model_newline();
        if ((m_row - m_top + ROWS) % ROWS < ROWS - 1) m_row = (m_row + 1) % ROWS;
        else begin
            m_top = (m_top + 1) % ROWS;
            m_row = (m_row + 1) % ROWS;
            push_blank_row(m_row);
        end
    endfunction

    function automatic void model_accept(input int ch);
        if (ch >= 32 && ch <= 126) begin
            qr.push_back(m_row); qc.push_back(m_col); qb.push_back(ch);
            if (m_col < COLS - 1) m_col++;
            else begin m_col = 0; model_newline(); end
        end else if (ch == 10) model_newline();
        else if (ch == 13) m_col = 0;
        else if (ch == 8) begin if (m_col > 0) m_col--; end
        else if (ch == 9) begin
            m_col = (m_col / TABW + 1) * TABW;
            if (m_col > COLS - 1) m_col = COLS - 1;
        end else if (ch == 12) begin
            for (int r = 0; r < ROWS; r++) push_blank_row(r);
            m_row = m_top; m_col = 0;
        end
    endfunction

    function automatic void model_reset();
        qr.delete(); qc.delete(); qb.delete();
        m_row = 0; m_col = 0; m_top = 0; wcnt = 0;
        for (int r = 0; r < ROWS; r++) push_blank_row(r);
    endfunction

    initial forever begin @(posedge clk); cyc++; end

    initial forever begin
        @(posedge clk); #1;
        case (wr_mode)
            0:       write_ready = 1'b1;
            1:       write_ready = ($urandom_range(0, 3) != 0);
            default: write_ready = 1'b0;
        endcase
    end

    // Compare process: samples at negedge, before the edge that acts on it.
    initial begin
        bit was_rst = 0, p_stall = 0;
        logic [1:0] p_row; logic [2:0] p_col; logic [7:0] p_byte;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_reset(); was_rst = 1; p_stall = 0;
            end else begin
                if (was_rst) begin
                    chk("rst_write_valid", write_valid, 0);
                    chk("rst_char_ready", character_ready, 0);
                    chk("rst_write_row", write_row, 0);
                    chk("rst_write_col", write_col, 0);
                    chk("rst_write_byte", write_byte, 8'h20);
                    chk("rst_top_row", top_row, 0);
                    chk("rst_cursor", {cursor_row, cursor_col}, 0);
                    was_rst = 0;
                end
                if (p_stall) begin
                    chk("stall_valid", write_valid, 1);
                    chk("stall_addr_data", {write_row, write_col, write_byte}, {p_row, p_col, p_byte});
                end
                if (character_ready) begin
                    chk("idle_pending_writes", qr.size(), 0);
                    chk("idle_write_valid", write_valid, 0);
                    chk("idle_cursor_row", cursor_row, m_row);
                    chk("idle_cursor_col", cursor_col, m_col);
                    chk("idle_top_row", top_row, m_top);
                end
                if (write_valid && write_ready) begin
                    wcnt++;
                    if (qr.size() == 0) chk("unexpected_write", 1, 0);
                    else chk("write_row_col_byte", {write_row, write_col, write_byte},
                             {2'(qr.pop_front()), 3'(qc.pop_front()), 8'(qb.pop_front())});
                end
                if (character_valid && character_ready) model_accept(int'(character_byte));
                p_stall = write_valid && !write_ready;
                p_row = write_row; p_col = write_col; p_byte = write_byte;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0; bit hs = 0;
        character_valid = 1'b1; character_byte = c;
        while (!hs && n < 3000) begin
            @(negedge clk); hs = character_ready;
            @(posedge clk); #1; n++;
        end
        if (!hs) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        int n = 0; bit rdy = 0;
        character_valid = 1'b0;
        while (!rdy && n < 3000) begin @(negedge clk); rdy = character_ready; n++; end
        if (!rdy) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        chk("global_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        int w0, c0, r;
        cycles(3); reset = 1'b0;
        wait_ready();
        chk("init_clear_writes", wcnt, 32);
        chk("init_cursor", {cursor_row, cursor_col}, 0);
        chk("init_top", top_row, 0);

        // 'A' under 3 cycles of backpressure
        wr_mode = 2; write_ready = 1'b0;
        send(8'h41); character_valid = 1'b0;
        cycles(3);
        chk("held_write", {write_valid, write_row, write_col, write_byte}, {1'b1, 2'd0, 3'd0, 8'h41});
        wr_mode = 0; write_ready = 1'b1;
        wait_ready();
        chk("after_A_cursor", {cursor_row, cursor_col}, {2'd0, 3'd1});

        send(8'h0D);
        w0 = wcnt;
        for (int i = 0; i < 8; i++) send(8'h61 + 8'(i));
        wait_ready();
        chk("a_to_h_writes", wcnt - w0, 8);
        chk("a_to_h_cursor", {cursor_row, cursor_col}, {2'd1, 3'd0});

        send(8'h0A); send(8'h0A); send(8'h78); send(8'h79);
        wait_ready();
        chk("pre_scroll_cursor", {top_row, cursor_row, cursor_col}, {2'd0, 2'd3, 3'd2});
        w0 = wcnt;
        send(8'h0A);
        wait_ready();
        chk("scroll_top_cursor", {top_row, cursor_row, cursor_col}, {2'd1, 2'd0, 3'd2});
        chk("scroll_clear_writes", wcnt - w0, 8);

        send(8'h61); send(8'h62); send(8'h63);
        wait_ready();
        w0 = wcnt;
        send(8'h09); wait_ready();
        chk("tab_from_5", cursor_col, 7);
        send(8'h0D); send(8'h7A); send(8'h09); wait_ready();
        chk("tab_from_1", cursor_col, 4);
        send(8'h0D); send(8'h08); wait_ready();
        chk("bs_at_0", cursor_col, 0);
        c0 = cyc;
        send(8'h0D); send(8'h08); send(8'h07); send(8'h09);
        chk("ctrl_burst_cycles", cyc - c0, 4);
        wait_ready();
        chk("ctrl_burst_col", cursor_col, 4);
        chk("ctrl_only_one_write", wcnt - w0, 1);

        w0 = wcnt;
        send(8'h0C); wait_ready();
        chk("ff_writes", wcnt - w0, 32);
        chk("ff_cursor_top", {top_row, cursor_row, cursor_col}, {2'd1, 2'd1, 3'd0});
        send(8'h0C); character_valid = 1'b0;
        cycles(10);
        reset = 1'b1; cycles(1); reset = 1'b0;
        wait_ready();
        chk("rst_restart_writes", wcnt, 32);
        chk("rst_restart_state", {top_row, cursor_row, cursor_col}, 0);

        // random traffic with random backpressure
        wr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin character_valid = 1'b0; cycles($urandom_range(1, 3)); end
            r = $urandom_range(0, 99);
            if (r < 60)      send(8'($urandom_range(32, 126)));
            else if (r < 70) send(8'h0A);
            else if (r < 75) send(8'h0D);
            else if (r < 80) send(8'h08);
            else if (r < 87) send(8'h09);
            else if (r < 89) send(8'h0C);
            else             send(8'($urandom_range(0, 255)));
        end
        wr_mode = 0; write_ready = 1'b1;
        wait_ready();
        chk("final_queue_empty", qr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
